// File: rtl/servo_pkg.sv
// Shared types and elaboration-time helpers for the servo PWM decoder.
// Constants are derived from the code width W (tick = 1 ms / 2^W).
package servo_pkg;

    typedef enum logic [1:0] {
        SEEK_LOW   = 2'd0,
        IDLE_LOW   = 2'd1,
        HIGH_COUNT = 2'd2
    } chan_state_t;

    localparam int DEFAULT_CLOCK_HZ   = 50_000_000;
    localparam int DEFAULT_CODE_WIDTH = 8;

    function automatic int servo_clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result++;
            rem = rem >> 1;
        end
        return result;
    endfunction

    // Address/counter widths never collapse to zero bits.
    function automatic int addr_width(input int n);
        return (servo_clog2(n) < 1) ? 1 : servo_clog2(n);
    endfunction

    function automatic int prescale_div(input int clock_hz, input int w);
        return clock_hz / (1000 * (1 << w));
    endfunction

    // 4 ms of ticks: any pulse this long is treated as a stuck/overlong input.
    function automatic int pulse_tick_limit(input int w);
        return 4 << w;
    endfunction

    // 32 ms of ticks without a rising edge marks the channel stale.
    function automatic int watchdog_tick_limit(input int w);
        return 32 << w;
    endfunction

endpackage

// File: rtl/servo_pulse_meter.sv
// One channel: synchronizer, optional majority filter (SERVO_DECODER_GLITCH_FILTER_EN),
// edge detect, measurement FSM, pulse/watchdog counters and the committed code.
module servo_pulse_meter
    import servo_pkg::*;
#(
    parameter int W = DEFAULT_CODE_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tick,
    input  logic         pwm_in,
    input  logic         clr_error,
    output logic [W-1:0] code,
    output logic         valid,
    output logic         strobe,
    output logic         error
);

    localparam int CW  = W + 3;
    localparam int WDW = W + 6;

    localparam logic [CW-1:0]  PULSE_LIMIT = CW'(pulse_tick_limit(W));
    localparam logic [CW-1:0]  CNT_MAX     = '1;
    localparam logic [CW-1:0]  LOW_BOUND   = CW'(1 << W);
    localparam logic [CW-1:0]  HIGH_BOUND  = CW'((2 << W) - 1);
    localparam logic [WDW-1:0] WD_LIMIT    = WDW'(watchdog_tick_limit(W));
    localparam logic [WDW-1:0] WD_MAX      = '1;

    logic [1:0]     sync_reg;
    logic           level;
    logic           cur_reg;
    logic           prev_reg;
    logic           rise;
    logic           fall;

    chan_state_t    state_reg, state_next;
    logic [CW-1:0]  count_reg, count_next;
    logic [WDW-1:0] wd_reg, wd_next;
    logic [W-1:0]   code_reg, code_next;
    logic           valid_reg, valid_next;
    logic           strobe_reg, strobe_next;
    logic           error_reg, error_next;

    function automatic logic [W-1:0] to_code(input logic [CW-1:0] c);
        if (c < LOW_BOUND) begin
            return '0;
        end else if (c >= HIGH_BOUND) begin
            return '1;
        end else begin
            return W'(c - LOW_BOUND);
        end
    endfunction

    // Pipeline resets to "line high" so a pulse in flight at reset release
    // produces no rising edge; SEEK_LOW then waits for a genuine low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= 2'b11;
            cur_reg  <= 1'b1;
            prev_reg <= 1'b1;
        end else begin
            sync_reg <= {sync_reg[0], pwm_in};
            cur_reg  <= level;
            prev_reg <= cur_reg;
        end
    end

`ifdef SERVO_DECODER_GLITCH_FILTER_EN
    logic [1:0] hist_reg;
    logic       filt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_reg <= 2'b11;
            filt_reg <= 1'b1;
        end else begin
            hist_reg <= {hist_reg[0], sync_reg[1]};
            filt_reg <= (sync_reg[1] & hist_reg[0]) | (sync_reg[1] & hist_reg[1]) |
                        (hist_reg[0] & hist_reg[1]);
        end
    end

    assign level = filt_reg;
`else
    assign level = sync_reg[1];
`endif

    assign rise = cur_reg & ~prev_reg;
    assign fall = ~cur_reg & prev_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= SEEK_LOW;
            count_reg  <= '0;
            wd_reg     <= '0;
            code_reg   <= '0;
            valid_reg  <= 1'b0;
            strobe_reg <= 1'b0;
            error_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            wd_reg     <= wd_next;
            code_reg   <= code_next;
            valid_reg  <= valid_next;
            strobe_reg <= strobe_next;
            error_reg  <= error_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        wd_next     = wd_reg;
        code_next   = code_reg;
        valid_next  = valid_reg;
        strobe_next = 1'b0;
        error_next  = error_reg;

        if (tick && (wd_reg != WD_MAX)) begin
            wd_next = wd_reg + 1'b1;
        end
        if (rise) begin
            wd_next = '0;
        end
        if (wd_reg >= WD_LIMIT) begin
            valid_next = 1'b0;
        end

        // Read-clear first so a same-cycle overlong detection still sets the flag.
        if (clr_error) begin
            error_next = 1'b0;
        end

        case (state_reg)
            SEEK_LOW: begin
                if (!cur_reg) begin
                    state_next = IDLE_LOW;
                end
            end
            IDLE_LOW: begin
                if (rise) begin
                    count_next = '0;
                    state_next = HIGH_COUNT;
                end
            end
            HIGH_COUNT: begin
                if (fall) begin
                    code_next   = to_code(count_reg);
                    strobe_next = 1'b1;
                    valid_next  = 1'b1;
                    state_next  = IDLE_LOW;
                end else if (count_reg >= PULSE_LIMIT) begin
                    error_next = 1'b1;
                    valid_next = 1'b0;
                    state_next = SEEK_LOW;
                end else if (tick && (count_reg != CNT_MAX)) begin
                    count_next = count_reg + 1'b1;
                end
            end
            default: begin
                state_next = SEEK_LOW;
            end
        endcase
    end

    assign code   = code_reg;
    assign valid  = valid_reg;
    assign strobe = strobe_reg;
    assign error  = error_reg;

endmodule

// File: rtl/n_channel_servo_pwm_decoder.sv
// N-channel servo pulse decoder: shared tick prescaler, per-channel meters and a
// registered read port. Optional glitch filter via SERVO_DECODER_GLITCH_FILTER_EN.
module n_channel_servo_pwm_decoder
    import servo_pkg::*;
#(
    parameter int NO_OF_CHANNEL    = 4,
    parameter int ADDRESS_WIDTH    = addr_width(NO_OF_CHANNEL),
    parameter int CLOCK_FREQUENCY  = DEFAULT_CLOCK_HZ,
    parameter int DUTY_CYCLE_WIDTH = DEFAULT_CODE_WIDTH
) (
    input  logic                        CLOCK,
    input  logic                        RESET,
    input  logic [NO_OF_CHANNEL-1:0]    PWM_INPUTS,
    input  logic [ADDRESS_WIDTH-1:0]    SERVO_SELECTOR,
    input  logic                        READ_ENABLE,
    output logic [DUTY_CYCLE_WIDTH-1:0] DUTY_CYCLE_OUT,
    output logic                        READ_VALID,
    output logic [NO_OF_CHANNEL-1:0]    CHANNEL_VALID,
    output logic [NO_OF_CHANNEL-1:0]    SAMPLE_STROBE,
    output logic [NO_OF_CHANNEL-1:0]    PULSE_ERROR
);

    localparam int W        = DUTY_CYCLE_WIDTH;
    localparam int PRESCALE = prescale_div(CLOCK_FREQUENCY, W);
    localparam int PW       = addr_width(PRESCALE);

    if (PRESCALE < 2) begin : g_prescale_check
        $error("servo decoder: PRESCALE must be at least 2 for this clock and code width");
    end

    logic [PW-1:0]            presc_reg;
    logic                     tick;
    logic [W-1:0]             code_arr [NO_OF_CHANNEL];
    logic [NO_OF_CHANNEL-1:0] clr_error;
    logic [W-1:0]             rd_data;

    assign tick = (presc_reg == PW'(PRESCALE - 1));

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            presc_reg <= '0;
        end else if (tick) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + 1'b1;
        end
    end

    genvar gi;
    for (gi = 0; gi < NO_OF_CHANNEL; gi++) begin : g_channel
        assign clr_error[gi] = READ_ENABLE && (SERVO_SELECTOR == ADDRESS_WIDTH'(gi));

        servo_pulse_meter #(
            .W(W)
        ) u_meter (
            .clk      (CLOCK),
            .rst_n    (RESET),
            .tick     (tick),
            .pwm_in   (PWM_INPUTS[gi]),
            .clr_error(clr_error[gi]),
            .code     (code_arr[gi]),
            .valid    (CHANNEL_VALID[gi]),
            .strobe   (SAMPLE_STROBE[gi]),
            .error    (PULSE_ERROR[gi])
        );
    end

    // Selectors with no matching channel fall through to zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NO_OF_CHANNEL; i++) begin
            if (SERVO_SELECTOR == ADDRESS_WIDTH'(i)) begin
                rd_data = code_arr[i];
            end
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            DUTY_CYCLE_OUT <= '0;
            READ_VALID     <= 1'b0;
        end else begin
            READ_VALID <= READ_ENABLE;
            if (READ_ENABLE) begin
                DUTY_CYCLE_OUT <= rd_data;
            end
        end
    end

endmodule
